// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into imem words, then releases the core.
// Optional trailing XOR checksum word is enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  input  logic [31:0]       IR_addr,
  output logic [31:0]       IR,
  input  logic [31:0]       im_rdata,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              im_wen_n,
  output logic              core_rst_n,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [32:0]     DEPTH = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE   = 1;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
  logic [ADDR_W:0]   r_word_idx;
  logic [ADDR_W:0]   r_len;
  logic [31:0]       r_wdata;
  logic              r_wen_n;
  logic              r_core_rst_n;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       r_csum;
`endif

  logic              w_active;
  logic              w_accept;
  logic              w_word_done;
  logic [31:0]       w_word;
  logic              w_last_wr;
  logic              w_reload;
  logic              w_unused_ir;

`ifdef LOADER_CHECKSUM_EN
  assign w_active = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CSUM);
`else
  assign w_active = (r_state == S_HDR) || (r_state == S_LOAD);
`endif

  assign rx_ready    = w_active & ~rst;
  assign w_accept    = rx_valid & rx_ready;
  assign w_word_done = w_accept & (r_byte_cnt == 2'd3);
  assign w_word      = {rx_data, r_asm};
  // The write pulse cycle of the final word decides the hand-off out of LOAD.
  assign w_last_wr   = ~r_wen_n & ((r_word_idx + ONE) == r_len);
  assign w_reload    = reload & ((r_state == S_RUN) || (r_state == S_ERR));
  assign w_unused_ir = ^{IR_addr[31:ADDR_W+2], IR_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_word_done) begin
          if ((w_word == 32'd0) || ({1'b0, w_word} > DEPTH)) w_state_nxt = S_ERR;
          else                                               w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_last_wr) w_state_nxt = S_CSUM;
`else
        if (w_last_wr) w_state_nxt = S_RUN;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_word_done) w_state_nxt = (w_word == r_csum) ? S_RUN : S_ERR;
      end
`endif
      S_RUN:   if (w_reload) w_state_nxt = S_HDR;
      S_ERR:   if (w_reload) w_state_nxt = S_HDR;
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt   <= 2'd0;
      r_asm        <= 24'd0;
      r_word_idx   <= '0;
      r_len        <= '0;
      r_wdata      <= 32'd0;
      r_wen_n      <= 1'b1;
      r_core_rst_n <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 32'd0;
`endif
    end else begin
      r_wen_n <= 1'b1;
      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0: r_asm[7:0]   <= rx_data;
          2'd1: r_asm[15:8]  <= rx_data;
          2'd2: r_asm[23:16] <= rx_data;
          2'd3: ;
        endcase
      end
      if ((r_state == S_HDR) && w_word_done) begin
        r_len      <= w_word[ADDR_W:0];
        r_word_idx <= '0;
      end
      if ((r_state == S_LOAD) && w_word_done) begin
        r_wdata <= w_word;
        r_wen_n <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_csum  <= r_csum ^ w_word;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      if (r_state == S_HDR) r_csum <= 32'd0;
`endif
      if (~r_wen_n) r_word_idx <= r_word_idx + ONE;
      // No bytes are accepted in RUN/ERR, so clearing here cannot race assembly.
      if (w_reload) begin
        r_byte_cnt <= 2'd0;
        r_word_idx <= '0;
        r_len      <= '0;
      end
      r_core_rst_n <= (w_state_nxt == S_RUN);
    end
  end

  assign im_addr    = (r_state == S_RUN) ? IR_addr[ADDR_W+1:2] : r_word_idx[ADDR_W-1:0];
  assign IR         = (r_state == S_RUN) ? im_rdata : 32'h0;
  assign im_wdata   = r_wdata;
  assign im_wen_n   = r_wen_n;
  assign core_rst_n = r_core_rst_n;
  assign busy       = w_active;
  assign err        = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboarded bench for imem_boot_loader: randomized byte streams against a memory-image model.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk, rst, rx_valid, rx_ready, reload;
  logic [7:0]        rx_data;
  logic [31:0]       IR_addr, IR, im_rdata, im_wdata;
  logic [ADDR_W-1:0] im_addr;
  logic              im_wen_n, core_rst_n, busy, err;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .IR_addr(IR_addr), .IR(IR), .im_rdata(im_rdata), .im_addr(im_addr),
    .im_wdata(im_wdata), .im_wen_n(im_wen_n), .core_rst_n(core_rst_n), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Behavioural memory attached to the loader
  logic [31:0] mem [DEPTH];
  logic        tb_clr;
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (!im_wen_n) begin
      mem[im_addr] <= im_wdata;
    end
  end
  assign im_rdata = mem[im_addr];

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  logic [31:0] ref_mem [DEPTH];
  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          n_chk, n_pass;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: every write pulse must match the next expected write
  always @(negedge clk) begin
    if (!rst && im_wen_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("write_unexpected", {31'b0, im_wen_n}, 32'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(im_addr), 32'(e.a));
        check("wr_data", im_wdata, e.d);
        check("core_rst_n_during_load", {31'b0, core_rst_n}, 32'd0);
        check("IR_during_load", IR, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    IR_addr  = $urandom;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) check("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic load_image(input int maxgap, input bit good_csum);
    logic [31:0] cs;
    cs = 32'd0;
    send_word(32'(img.size()), maxgap);
    // reload must be ignored while loading
    @(negedge clk); reload = 1'b1;
    @(posedge clk); #1 reload = 1'b0;
    @(negedge clk); check("busy_reload_ignored", {31'b0, busy}, 32'd1);
    for (int i = 0; i < img.size(); i++) begin
      ref_mem[i] = img[i];
      exp_q.push_back('{a: ADDR_W'(i), d: img[i]});
      cs ^= img[i];
      send_word(img[i], maxgap);
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(good_csum ? cs : ~cs, maxgap);
`else
    if (!good_csum) cs = ~cs;
`endif
  endtask

  task automatic expect_run();
`ifndef LOADER_CHECKSUM_EN
    @(negedge clk); check("core_rst_n_last_pulse", {31'b0, core_rst_n}, 32'd0);
`endif
    @(negedge clk);
    check("core_rst_n_rise", {31'b0, core_rst_n}, 32'd1);
    check("busy_run", {31'b0, busy}, 32'd0);
    check("rx_ready_run", {31'b0, rx_ready}, 32'd0);
    check("err_run", {31'b0, err}, 32'd0);
  endtask

  task automatic expect_err();
    @(negedge clk);
    check("err_set", {31'b0, err}, 32'd1);
    check("rx_ready_err", {31'b0, rx_ready}, 32'd0);
    check("core_rst_n_err", {31'b0, core_rst_n}, 32'd0);
    check("busy_err", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_read(input logic [31:0] a);
    logic [ADDR_W-1:0] w;
    @(negedge clk);
    IR_addr = a;
    w = a[ADDR_W+1:2];
    #1;
    check("run_im_addr", 32'(im_addr), 32'(w));
    check("run_IR", IR, ref_mem[w]);
  endtask

  task automatic do_reload();
    @(negedge clk); reload = 1'b1;
    @(posedge clk); #1 reload = 1'b0;
    @(negedge clk);
    check("reload_busy", {31'b0, busy}, 32'd1);
    check("reload_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("reload_err", {31'b0, err}, 32'd0);
    check("reload_rx_ready", {31'b0, rx_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b0; tb_clr = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0; IR_addr = 32'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_im_wen_n", {31'b0, im_wen_n}, 32'd1);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_IR", IR, 32'd0);
    tb_clr = 1'b0;
    rst = 1'b0;

    // Two-word image
    img = {32'h2008_0005, 32'h2009_000A};
    load_image(0, 1'b1);
    expect_run();
    run_read(32'h0000_0004);
    run_read(32'h0000_0000);
    run_read(32'hFFFF_FC04);

    // Reload from RUN with a one-word image
    do_reload();
    img = {32'h0800_0000};
    load_image(0, 1'b1);
    expect_run();
    run_read(32'h0000_0000);
    run_read(32'h0000_0004);

    // Illegal headers
    do_reload();
    send_word(32'd0, 0);
    expect_err();
    do_reload();
    send_word(32'(DEPTH + 1), 0);
    expect_err();
    repeat (3) @(negedge clk);
    check("err_sticky", {31'b0, err}, 32'd1);
    do_reload();

    // Reset in the middle of a word
    send_word(32'd3, 2);
    ref_mem[0] = 32'h1234_5678;
    exp_q.push_back('{a: '0, d: 32'h1234_5678});
    send_word(32'h1234_5678, 2);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd1);
    check("midrst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("midrst_im_wen_n", {31'b0, im_wen_n}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Randomized images with gaps, each followed by a reload
    for (int k = 0; k < 5; k++) begin
      int n;
      n = int'($urandom_range(1, 20));
      img = {};
      for (int i = 0; i < n; i++) img.push_back($urandom);
      load_image(5, 1'b1);
      expect_run();
      for (int i = 0; i < 6; i++) run_read($urandom);
      run_read(32'(n - 1) << 2);
      run_read(32'(n) << 2);
      do_reload();
    end

    // Full-depth image, reads wrap modulo depth
    img = {};
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    load_image(0, 1'b1);
    expect_run();
    for (int i = 0; i < DEPTH; i += 17) run_read((32'($urandom_range(0, 255)) << (ADDR_W + 2)) | (32'(i) << 2));
    run_read(32'(DEPTH - 1) << 2);

`ifdef LOADER_CHECKSUM_EN
    do_reload();
    img = {32'h0000_FFFF, 32'hFFFF_0000};
    load_image(0, 1'b1);
    expect_run();
    run_read(32'h0000_0004);
    do_reload();
    load_image(0, 1'b0);
    expect_err();
    do_reload();
`endif

    repeat (4) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
